// File: rtl/axi_rd_burst_engine_if.sv
// AXI read-slave AR/R channel bundle.
// master drives AR and RREADY, slave drives ARREADY and R.
interface axi_rd_burst_engine_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2
);
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [3:0]        ARLEN;
  logic [1:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic [1:0]        ARLOCK;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE,
    output ARBURST, ARLOCK, ARVALID,
    output RREADY,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE,
    input  ARBURST, ARLOCK, ARVALID,
    input  RREADY,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_rd_burst_engine.sv
// AXI read burst engine: AR -> per-beat memory reads -> R beats.
// Optional RD_EXCL_OKAY_EN: exclusive bursts answer EXOKAY.
module axi_rd_burst_engine #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 2,
  parameter int MEM_AW    = 7,
  parameter int MEM_BYTES = 128
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  axi_rd_burst_engine_if.slave axi,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CAPT,
    RESP
  } state_t;

  localparam logic [1:0] RS_OKAY   = 2'b00;
  localparam logic [1:0] RS_EXOKAY = 2'b01;
  localparam logic [1:0] RS_SLVERR = 2'b10;
  localparam logic [1:0] RS_DECERR = 2'b11;

  localparam logic [ADDR_W-1:0] MEM_TOP =
    ADDR_W'(MEM_BYTES);

  state_t            state;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        len_q;
  logic [1:0]        size_q;
  logic [1:0]        burst_q;
  logic [1:0]        lock_q;
  logic [3:0]        cnt_q;
  logic              berr_q;
  logic              rd_q;

  logic [ADDR_W-1:0] ar_incr;
  logic              ar_wlen_ok;
  logic              ar_berr;
  logic              ar_rd;

  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] bound;
  logic [ADDR_W-1:0] nxt_addr;
  logic              nxt_rd;
  logic [1:0]        ok_code;

  // Burst-level legality of the incoming AR request.
  always_comb begin
    ar_incr    = ADDR_W'(1) << axi.ARSIZE;
    ar_wlen_ok = 1'b0;
    unique case (1'b1)
      axi.ARLEN == 4'd1:  ar_wlen_ok = 1'b1;
      axi.ARLEN == 4'd3:  ar_wlen_ok = 1'b1;
      axi.ARLEN == 4'd7:  ar_wlen_ok = 1'b1;
      axi.ARLEN == 4'd15: ar_wlen_ok = 1'b1;
      default:            ar_wlen_ok = 1'b0;
    endcase
    ar_berr = (axi.ARSIZE == 2'd3)
            | (axi.ARBURST == 2'd3);
    if (axi.ARBURST == 2'd2) begin
      ar_berr = ar_berr | ~ar_wlen_ok
              | ((axi.ARADDR & (ar_incr - 1'b1)) != '0);
    end
    ar_rd = ~ar_berr & (axi.ARADDR < MEM_TOP);
  end

  // Next beat address and whether it may be read.
  always_comb begin
    incr  = ADDR_W'(1) << size_q;
    bound = ADDR_W'({1'b0, len_q} + 5'd1) << size_q;
    nxt_addr = addr_q;
    unique case (1'b1)
      burst_q == 2'd1:
        nxt_addr = (addr_q & ~(incr - 1'b1)) + incr;
      burst_q == 2'd2:
        nxt_addr = (addr_q & ~(bound - 1'b1))
                 | ((addr_q + incr) & (bound - 1'b1));
      default:
        nxt_addr = addr_q;
    endcase
    nxt_rd = ~berr_q & (nxt_addr < MEM_TOP);
  end

`ifdef RD_EXCL_OKAY_EN
  assign ok_code = (lock_q == 2'b01) ? RS_EXOKAY
                                     : RS_OKAY;
`else
  logic lock_unused;
  assign lock_unused = ^lock_q;
  assign ok_code     = RS_OKAY;
`endif

  // Burst sequencer: accept, fetch, capture, hand out one beat.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      lock_q     <= '0;
      cnt_q      <= '0;
      berr_q     <= 1'b0;
      rd_q       <= 1'b0;
      axi.ARREADY <= 1'b0;
      axi.RVALID <= 1'b0;
      axi.RLAST  <= 1'b0;
      axi.RID    <= '0;
      axi.RRESP  <= RS_OKAY;
      axi.RDATA  <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
    end else begin
      mem_rd <= 1'b0;
      unique case (state)
        IDLE: begin
          axi.ARREADY <= 1'b1;
          if (axi.ARVALID && axi.ARREADY) begin
            id_q    <= axi.ARID;
            addr_q  <= axi.ARADDR;
            len_q   <= axi.ARLEN;
            size_q  <= axi.ARSIZE;
            burst_q <= axi.ARBURST;
            lock_q  <= axi.ARLOCK;
            cnt_q   <= '0;
            berr_q  <= ar_berr;
            rd_q    <= ar_rd;
            mem_rd  <= ar_rd;
            if (ar_rd) begin
              mem_addr <= axi.ARADDR[MEM_AW-1:0];
            end
            axi.ARREADY <= 1'b0;
            state <= FETCH;
          end
        end
        FETCH: begin
          state <= CAPT;
        end
        CAPT: begin
          axi.RDATA <= rd_q ? mem_rdata : '0;
          if (berr_q) begin
            axi.RRESP <= RS_SLVERR;
          end else if (!rd_q) begin
            axi.RRESP <= RS_DECERR;
          end else begin
            axi.RRESP <= ok_code;
          end
          axi.RLAST  <= (cnt_q == len_q);
          axi.RID    <= id_q;
          axi.RVALID <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          if (axi.RREADY) begin
            axi.RVALID <= 1'b0;
            if (axi.RLAST) begin
              axi.ARREADY <= 1'b1;
              state <= IDLE;
            end else begin
              cnt_q  <= cnt_q + 4'd1;
              addr_q <= nxt_addr;
              rd_q   <= nxt_rd;
              mem_rd <= nxt_rd;
              if (nxt_rd) begin
                mem_addr <= nxt_addr[MEM_AW-1:0];
              end
              state <= FETCH;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/axi_rd_burst_engine.md
Name: axi_rd_burst_engine

Overview:
- Read-slave back end between the slave AR channel and the on-chip Memory model.
- Accepts one AR transaction at a time and expands it into per-beat byte addresses using FIXED, INCR or WRAP bursts.
- Issues one memory read per beat and returns each beat on the R channel with RID, RRESP, RLAST and full RREADY backpressure.
- Consumes the 2-bit slave-side ID and produces the R beats that the master-side R stage receives.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, RDATA and mem_rdata width.
- ID_W, 2, ARID/RID width; the slave-side ID includes the appended master bit.
- MEM_AW, 7, memory address width; mem_addr = addr[MEM_AW-1:0].
- MEM_BYTES, 128, decoded memory size in bytes.

Ports:
- ACLK  in  1  clock, rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- ARID  in  ID_W  transaction ID.
- ARADDR  in  ADDR_W  start byte address.
- ARLEN  in  4  beats minus 1.
- ARSIZE  in  2  bytes per beat: 0=1, 1=2, 2=4, 3=illegal.
- ARBURST  in  2  burst type: 0=FIXED, 1=INCR, 2=WRAP, 3=illegal.
- ARLOCK  in  2  lock type; 01 = exclusive.
- ARVALID  in  1  address valid.
- ARREADY  out  1  address ready.
- RID  out  ID_W  echoed ID.
- RDATA  out  DATA_W  beat data.
- RRESP  out  2  00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR.
- RLAST  out  1  final beat of the burst.
- RVALID  out  1  beat valid.
- RREADY  in  1  master ready.
- mem_addr  out  MEM_AW  memory byte address.
- mem_rd  out  1  memory read strobe.
- mem_rdata  in  DATA_W  memory data; valid the cycle after mem_rd.

Behaviour:
- Reset: ARESETn low asynchronously forces state IDLE and clears all outputs: ARREADY=0, RVALID=0, RLAST=0, RID=0, RRESP=0, RDATA=0, mem_rd=0, mem_addr=0.
- Reset mid-burst: the burst is discarded and no further beats are sent. ARREADY rises the first cycle after deassertion.
- FSM states: IDLE, FETCH, CAPT, RESP.
- IDLE:
  - ARREADY=1.
  - On ARVALID&ARREADY, latch id, addr, len, size, burst and lock; set beat count = 0; compute the error flag; go to FETCH.
- FETCH:
  - ARREADY=0.
  - If the beat is legal and addr < MEM_BYTES: mem_rd=1 and mem_addr=addr[MEM_AW-1:0] for exactly one cycle.
  - Otherwise mem_rd=0.
  - Go to CAPT.
- CAPT:
  - RDATA<=mem_rdata if a read was issued, else 0.
  - RRESP<=beat response; RLAST<=(count==len); RID<=id; RVALID<=1.
  - Go to RESP.
- RESP:
  - Hold RVALID, RDATA, RRESP, RLAST and RID stable until RREADY.
  - On handshake: RVALID<=0. If RLAST, go to IDLE. Otherwise count+1, advance the address, go to FETCH.
- Latency: AR handshake to first RVALID is 3 cycles. Throughput is 1 beat per 3 cycles when RREADY is held high.
- Address advance, with incr = 1<<size:
  - FIXED: address unchanged.
  - INCR: addr = (addr & ~(incr-1)) + incr; the first beat may be unaligned; wraps mod 2^ADDR_W.
  - WRAP: bound = (len+1)*incr; addr = (addr & ~(bound-1)) | ((addr+incr) & (bound-1)).
- Burst error (SLVERR on every beat, no mem_rd for the whole burst) when any of:
  - ARSIZE=3.
  - ARBURST=3.
  - WRAP with len not in {1,3,7,15}.
  - WRAP with a start address not aligned to incr.
- Beat error (DECERR on that beat only, no mem_rd, RDATA=0): a non-error burst beat whose addr >= MEM_BYTES.
- Otherwise RRESP=OKAY.
- RDATA carries the memory word unaltered; no lane steering.
- Only one burst is in flight at a time. ARREADY stays low from acceptance until the cycle after the last R handshake.
- Beats always complete in order.

Optional Feature:
- Macro RD_EXCL_OKAY_EN.
- Defined: a burst accepted with ARLOCK=2'b01 returns EXOKAY (01) in place of OKAY on every beat. SLVERR and DECERR are unchanged.
- Undefined: ARLOCK is latched but ignored; OKAY is returned as normal.

Test Plan:
- INCR burst: ARID=2, ADDR=0x00, LEN=3, SIZE=1 -> mem_addr sequence 0x00,0x02,0x04,0x06; 4 beats with RID=2 and RRESP=00; RLAST on beat 4 only; ARREADY low throughout.
- Backpressure: ADDR=0x08, LEN=2, SIZE=2, RREADY low 5 cycles on beat 2 -> RDATA/RRESP/RLAST stable; exactly 3 mem_rd pulses total at 0x08,0x0C,0x10.
- WRAP burst: ADDR=0x18, LEN=3, SIZE=2, BURST=2 -> addresses 0x18,0x1C,0x10,0x14; all OKAY.
- Errors:
  - SIZE=3, LEN=1 -> 2 beats of SLVERR, RDATA=0, zero mem_rd.
  - INCR ADDR=0x7C, SIZE=2, LEN=1 -> beat 1 OKAY from 0x7C, beat 2 DECERR with no mem_rd.
- Reset mid-burst: ARESETn low during RESP of beat 2 of 4 -> RVALID=0 immediately; after release ARREADY=1 and a new burst runs normally.
- Exclusive access: ARLOCK=01, LEN=0 -> RRESP=01 with RD_EXCL_OKAY_EN defined, 00 without.
